// File: rtl/pix_ctrl_pkg.sv
// Shared types and constants for the pixel sequencer controller.
package pix_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2,
    StSwitch = 2'd3
  } state_e;

  localparam logic [3:0] OffCtrl     = 4'h0;
  localparam logic [3:0] OffMode     = 4'h4;
  localparam logic [3:0] OffFrameLen = 4'h8;
  localparam logic [3:0] OffStatus   = 4'hC;

  localparam logic [1:0] ModeBypass = 2'b00;
  localparam logic [1:0] ModeInvert = 2'b01;
  localparam logic [1:0] ModeConv   = 2'b10;

  // The reserved encoding falls back to bypass.
  function automatic logic [1:0] legal_mode(input logic [1:0] m);
    return (m == 2'b11) ? ModeBypass : m;
  endfunction

endpackage

// File: rtl/pix_ctrl_regs.sv
// CPU-visible register file and single-cycle bus handshake for pix_seq_ctrl.
module pix_ctrl_regs
  import pix_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [3:0]       iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  state_e           state,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic             done_set,
  input  logic             ovf_set,
  output logic             start_req,
  output logic             abort_req,
  output logic             continuous,
  output logic             irq,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] frame_len
);

  logic             ready_q, cont_q, irq_en_q, done_q, ovf_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] len_q, len_new;
  logic [31:0]      rdata_q, rd_val, wmask, fc_ext;
  logic [3:0]       offset;
  logic             access, wr, wr_ctrl, wr_mode, wr_len, wr_status;
  logic             unused_bits;

  assign access    = iomem_valid && !ready_q;
  assign wr        = access && (iomem_wstrb != 4'b0000);
  assign offset    = {iomem_addr[3:2], 2'b00};
  assign wr_ctrl   = wr && (offset == OffCtrl) && iomem_wstrb[0];
  assign wr_mode   = wr && (offset == OffMode) && iomem_wstrb[0];
  assign wr_len    = wr && (offset == OffFrameLen);
  assign wr_status = wr && (offset == OffStatus) && iomem_wstrb[0];
  assign start_req = wr_ctrl && iomem_wdata[0];
  assign abort_req = wr_ctrl && iomem_wdata[2];

  assign wmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}},
                    {8{iomem_wstrb[0]}}};
  assign len_new = (len_q & ~wmask[CNT_W-1:0]) | (iomem_wdata[CNT_W-1:0] & wmask[CNT_W-1:0]);
  assign fc_ext  = 32'(frame_cnt);

  assign unused_bits = ^{iomem_addr[1:0], wmask, iomem_wdata, fc_ext};

  always_comb begin
    rd_val = '0;
    case (offset)
      OffCtrl:     rd_val = {28'b0, irq_en_q, 1'b0, cont_q, 1'b0};
      OffMode:     rd_val = {30'b0, mode_q};
      OffFrameLen: rd_val = 32'(len_q);
      OffStatus:   rd_val = {fc_ext[15:0], 12'b0, ovf_q, done_q, state};
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      mode_q   <= ModeBypass;
      len_q    <= CNT_W'(FRAME_PIXELS);
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q <= access;
      rdata_q <= access ? rd_val : '0;
      if (wr_ctrl) begin
        cont_q   <= iomem_wdata[1];
        irq_en_q <= iomem_wdata[3];
      end
      if (wr_mode) mode_q <= legal_mode(iomem_wdata[1:0]);
      if (wr_len && (len_new != '0)) len_q <= len_new;
      // A hardware set in the same cycle as a clear wins, so no event is lost.
      done_q <= done_set || (done_q && !(wr_status && iomem_wdata[2]));
      ovf_q  <= ovf_set || (ovf_q && !(wr_status && iomem_wdata[3]));
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign continuous  = cont_q;
  assign mode        = mode_q;
  assign frame_len   = len_q;
  assign irq         = irq_en_q && (done_q || ovf_q);

endmodule

// File: rtl/pix_seq_ctrl.sv
// Frame sequencer: feeds a pixel engine one frame at a time and tracks its output count.
module pix_seq_ctrl
  import pix_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [3:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        pix_in_valid,
  output logic        pix_in_ready,
  input  logic        proc_valid,
  output logic [1:0]  eng_mode,
  output logic        eng_flush,
  output logic        irq
);

  state_e           state_q;
  logic [CNT_W-1:0] in_cnt_q, out_cnt_q, cur_len_q, frame_cnt_q, frame_len, in_cnt_inc;
  logic [1:0]       mode, eng_mode_q;
  logic             eng_flush_q, pix_in_ready_q;
  logic             start_req, abort_req, continuous;
  logic             accept, out_count, frame_end, load_frame, done_set, ovf_set;

  pix_ctrl_regs #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .CNT_W       (CNT_W)
  ) u_regs (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .state      (state_q),
    .frame_cnt  (frame_cnt_q),
    .done_set   (done_set),
    .ovf_set    (ovf_set),
    .start_req  (start_req),
    .abort_req  (abort_req),
    .continuous (continuous),
    .irq        (irq),
    .mode       (mode),
    .frame_len  (frame_len)
  );

  assign accept     = (state_q == StRun) && pix_in_ready_q && pix_in_valid;
  assign out_count  = proc_valid && ((state_q == StRun) || (state_q == StDrain)) &&
                      (out_cnt_q != cur_len_q);
  // Any engine strobe that cannot be attributed to the current frame is an overflow.
  assign ovf_set    = proc_valid && !out_count;
  assign frame_end  = (state_q == StDrain) && (out_cnt_q == cur_len_q);
  assign done_set   = frame_end && !abort_req;
  assign load_frame = !abort_req && (((state_q == StIdle) && start_req) || (state_q == StSwitch));
  assign in_cnt_inc = in_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      cur_len_q      <= CNT_W'(FRAME_PIXELS);
      frame_cnt_q    <= '0;
      eng_mode_q     <= ModeBypass;
      eng_flush_q    <= 1'b0;
      pix_in_ready_q <= 1'b0;
    end else begin
      eng_flush_q <= 1'b0;
      if (abort_req) begin
        state_q        <= StIdle;
        pix_in_ready_q <= 1'b0;
        eng_flush_q    <= 1'b1;
        in_cnt_q       <= '0;
        out_cnt_q      <= '0;
      end else if (load_frame) begin
        // Mode and length are latched here so mid-frame register writes wait a frame.
        state_q        <= StRun;
        pix_in_ready_q <= 1'b1;
        eng_flush_q    <= 1'b1;
        in_cnt_q       <= '0;
        out_cnt_q      <= '0;
        eng_mode_q     <= mode;
        cur_len_q      <= frame_len;
      end else begin
        if (out_count) out_cnt_q <= out_cnt_q + CNT_W'(1);
        case (state_q)
          StRun: begin
            if (accept) begin
              in_cnt_q <= in_cnt_inc;
              if (in_cnt_inc == cur_len_q) begin
                state_q        <= StDrain;
                pix_in_ready_q <= 1'b0;
              end
            end
          end
          StDrain: begin
            if (frame_end) begin
              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
              state_q     <= continuous ? StSwitch : StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pix_in_ready = pix_in_ready_q;
  assign eng_mode     = eng_mode_q;
  assign eng_flush    = eng_flush_q;

endmodule

// File: tb/tb_pix_seq_ctrl.sv
// Bench for pix_seq_ctrl: frame-level reference model checked every cycle plus directed checks.
module tb_pix_seq_ctrl;

  localparam int unsigned FramePixels = 1024;
  localparam int unsigned CntW        = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [3:0]  iomem_addr = 4'h0;
  logic [31:0] iomem_wdata = '0;
  logic        pix_in_valid = 1'b0;
  logic        proc_valid = 1'b0;
  logic        iomem_ready, pix_in_ready, eng_flush, irq;
  logic [31:0] iomem_rdata;
  logic [1:0]  eng_mode;

  int n_cmp = 0;
  int n_fail = 0;

  pix_seq_ctrl #(
    .FRAME_PIXELS(FramePixels),
    .CNT_W       (CntW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pix_in_valid(pix_in_valid),
    .pix_in_ready(pix_in_ready),
    .proc_valid  (proc_valid),
    .eng_mode    (eng_mode),
    .eng_flush   (eng_flush),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase: 0 idle, 1 run, 2 drain, 3 switch) ----------------
  int          m_phase, m_in, m_out, m_cur_len, m_fcnt, m_len, m_mode, m_emode;
  bit          m_ack, m_rdy, m_flush, m_cont, m_irqen, m_done, m_ovf;
  logic [31:0] m_rdata;

  function automatic logic [31:0] model_reg(input int idx);
    case (idx)
      0:       return 32'((m_cont ? 2 : 0) + (m_irqen ? 8 : 0));
      1:       return 32'(m_mode);
      2:       return 32'(m_len);
      default: return (32'(m_fcnt) << 16) + 32'((m_ovf ? 8 : 0) + (m_done ? 4 : 0) + m_phase);
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_in = 0; m_out = 0; m_fcnt = 0;
    m_cur_len = FramePixels; m_len = FramePixels; m_mode = 0; m_emode = 0;
    m_ack = 0; m_rdy = 0; m_flush = 0; m_cont = 0; m_irqen = 0; m_done = 0; m_ovf = 0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    int          idx = int'(iomem_addr[3:2]);
    bit          req = iomem_valid && !m_ack;
    bit          wr = req && (iomem_wstrb != 4'h0);
    bit          start = wr && idx == 0 && iomem_wdata[0];
    bit          abort = wr && idx == 0 && iomem_wdata[2];
    bit          took = m_phase == 1 && m_rdy && pix_in_valid;
    bit          counted = proc_valid && (m_phase == 1 || m_phase == 2) && m_out < m_cur_len;
    bit          spill = proc_valid && !counted;
    bit          ended = m_phase == 2 && m_out == m_cur_len && !abort;
    logic [31:0] rd = model_reg(idx);
    m_flush = 0;
    if (abort) begin
      m_phase = 0; m_rdy = 0; m_flush = 1; m_in = 0; m_out = 0;
    end else if ((m_phase == 0 && start) || m_phase == 3) begin
      m_phase = 1; m_rdy = 1; m_flush = 1; m_in = 0; m_out = 0;
      m_emode = m_mode; m_cur_len = m_len;
    end else if (m_phase == 1) begin
      m_in += int'(took);
      m_out += int'(counted);
      if (m_in == m_cur_len) begin m_phase = 2; m_rdy = 0; end
    end else if (m_phase == 2) begin
      m_out += int'(counted);
      if (ended) begin
        m_fcnt = (m_fcnt + 1) % (1 << CntW);
        m_phase = m_cont ? 3 : 0;
      end
    end
    m_done = ended || (m_done && !(wr && idx == 3 && iomem_wdata[2]));
    m_ovf  = spill || (m_ovf && !(wr && idx == 3 && iomem_wdata[3]));
    if (wr && idx == 0) begin m_cont = iomem_wdata[1]; m_irqen = iomem_wdata[3]; end
    if (wr && idx == 1) m_mode = (iomem_wdata[1:0] == 2'b11) ? 0 : int'(iomem_wdata[1:0]);
    if (wr && idx == 2 && iomem_wdata[15:0] != 16'h0) m_len = int'(iomem_wdata[15:0]);
    m_ack = req;
    m_rdata = req ? rd : '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetn) model_reset();
      else model_step();
      @(negedge clk);
      check("iomem_ready", 32'(iomem_ready), 32'(m_ack));
      check("iomem_rdata", iomem_rdata, m_rdata);
      check("pix_in_ready", 32'(pix_in_ready), 32'(m_rdy));
      check("eng_mode", 32'(eng_mode), 32'(m_emode));
      check("eng_flush", 32'(eng_flush), 32'(m_flush));
      check("irq", 32'(irq), 32'(m_irqen && (m_done || m_ovf)));
    end
  end

  // ---------------- engine: proc_valid two cycles after each accept ----------------
  int budget = 1000;
  int n_acc = 0;
  bit pv_force = 0;
  bit p1 = 0, p2 = 0;

  initial begin
    bit acc, pv;
    forever begin
      @(posedge clk);
      acc = resetn && pix_in_valid && pix_in_ready;
      if (acc) n_acc++;
      @(negedge clk);
      p2 = p1;
      p1 = acc;
      pv = p2 && budget > 0;
      if (pv) budget--;
      proc_valid = pv || pv_force;
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_xfer(input logic [3:0] addr, input logic [3:0] strb, input logic [31:0] data,
                          output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin got = 1; rd = iomem_rdata; end
    end
    @(negedge clk);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_wdata = '0;
    check("bus_ack", 32'(got), 32'd1);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] d;
    bus_xfer(addr, 4'hF, data, d);
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] rd);
    bus_xfer(addr, 4'h0, '0, rd);
  endtask

  task automatic expect_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(addr, rd);
    check(name, rd, exp);
  endtask

  task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input string name);
    logic [31:0] rd;
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      bus_read(4'hC, rd);
      if ((rd & mask) == val) hit = 1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic pulse_pv();
    @(posedge clk); #2; pv_force = 1;
    @(posedge clk); #2; pv_force = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #12;
    check("reset_outputs", {24'(iomem_rdata != 0), iomem_ready, pix_in_ready, eng_mode,
                            eng_flush, irq, 2'b00}, 32'h0);
    #10 resetn = 1'b1;

    expect_reg("rst_ctrl", 4'h0, 32'h0);
    expect_reg("rst_mode", 4'h4, 32'h0);
    expect_reg("rst_frame_len", 4'h8, 32'd1024);
    expect_reg("rst_status", 4'hC, 32'h0);

    // Single frame of 8 pixels in invert mode.
    bus_write(4'h8, 32'd8);
    bus_write(4'h4, 32'd1);
    @(posedge clk); #2; n_acc = 0;
    @(negedge clk); pix_in_valid = 1'b1;
    bus_write(4'h0, 32'h1);
    check("start_flush", 32'(eng_flush), 32'd1);
    check("start_mode", 32'(eng_mode), 32'd1);
    wait_status(32'h7, 32'h4, "frame1_done");
    check("frame1_accepts", 32'(n_acc), 32'd8);
    expect_reg("frame1_status", 4'hC, 32'h0001_0004);

    // Continuous run with a mid-frame mode change.
    bus_write(4'hC, 32'h4);
    bus_write(4'h4, 32'd0);
    bus_write(4'h0, 32'h3);
    bus_write(4'h4, 32'd2);
    check("cont_mode_held", 32'(eng_mode), 32'd0);
    wait_status(32'hFFFF_0000, 32'h0002_0000, "cont_first_done");
    check("cont_mode_switched", 32'(eng_mode), 32'd2);
    bus_write(4'h0, 32'h0);
    wait_status(32'hFFFF_0007, 32'h0003_0004, "cont_second_done");

    // Abort during drain with 5 of 8 outputs seen.
    bus_write(4'hC, 32'h4);
    @(posedge clk); #2; budget = 5;
    bus_write(4'h0, 32'h1);
    wait_status(32'h3, 32'h2, "reach_drain");
    repeat (4) @(negedge clk);
    bus_write(4'h0, 32'h4);
    check("abort_flush", 32'(eng_flush), 32'd1);
    check("abort_ready", 32'(pix_in_ready), 32'd0);
    expect_reg("abort_status", 4'hC, 32'h0003_0000);
    @(posedge clk); #2; budget = 1000;

    // Overflow and interrupt behaviour.
    bus_write(4'h0, 32'h9);
    wait_status(32'h7, 32'h4, "irq_frame_done");
    check("irq_on_done", 32'(irq), 32'd1);
    bus_write(4'hC, 32'h4);
    check("irq_after_done_clr", 32'(irq), 32'd0);
    pulse_pv();
    @(negedge clk);
    check("irq_on_ovf", 32'(irq), 32'd1);
    expect_reg("ovf_status", 4'hC, 32'h0004_0008);
    bus_write(4'hC, 32'h8);
    check("irq_after_ovf_clr", 32'(irq), 32'd0);
    expect_reg("ovf_cleared", 4'hC, 32'h0004_0000);

    // Ignored writes while a frame is running.
    @(negedge clk); pix_in_valid = 1'b0;
    bus_write(4'h0, 32'h1);
    expect_reg("run_status", 4'hC, 32'h0004_0001);
    bus_write(4'h0, 32'h1);
    check("restart_no_flush", 32'(eng_flush), 32'd0);
    bus_write(4'h4, 32'd3);
    expect_reg("mode_11_reads_00", 4'h4, 32'h0);
    bus_write(4'h8, 32'd0);
    expect_reg("len_0_ignored", 4'h8, 32'd8);
    check("run_mode", 32'(eng_mode), 32'd2);
    @(negedge clk); pix_in_valid = 1'b1;
    wait_status(32'hFFFF_0007, 32'h0005_0004, "last_frame_done");

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
